hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL be module hazard_unit with a single modport-style port huif of interface type hazard_unit_if, plus clock and reset; one clock, reset synchronous and active-low.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  synchronous active-low reset.
REQ-004 huif.ihit  in  1  instruction fetch complete this cycle.
REQ-005 huif.dhit  in  1  data memory access complete this cycle.
REQ-006 huif.dmem_req  in  1  MEM-stage instruction has a pending load/store (dREN|dWEN).
REQ-007 huif.ex_instr  in  32  instruction currently in EX stage.
REQ-008 huif.id_instr  in  32  instruction currently in ID stage.
REQ-009 huif.mem_branch_taken  in  1  taken branch resolved in MEM.
REQ-010 huif.mem_jump  in  1  jump (J/JAL/JR) resolved in MEM.
REQ-011 huif.pcEN, fdEN, dxEN, xmEN, mwEN  out  1 each  PC and pipeline-latch enables.
REQ-012 huif.fd_flush, dx_flush, xm_flush  out  1 each  pipeline-latch flushes (bubble insert).
REQ-013 huif.stall_count  out  32  registered count of load-use stall cycles.

Function
REQ-014 All enable and flush outputs SHALL be purely combinational on the current inputs (zero-cycle latency).
REQ-015 load_use SHALL be true when ex_instr[31:26] == LW (6'b100011), subject to REQ-027.
REQ-016 Priority 1, memory wait (dmem_req && !dhit): all five enables 0, all flushes 0.
REQ-017 Priority 2, control hazard (mem_branch_taken || mem_jump): all enables = ihit; fd_flush = dx_flush = xm_flush = ihit.
REQ-018 Priority 3, load-use: pcEN = 0, fdEN = 0; dxEN = xmEN = mwEN = ihit; dx_flush = ihit; fd_flush = xm_flush = 0.
REQ-019 Otherwise (normal): all enables = ihit; all flushes 0.
REQ-020 ihit = 0 in any non-memory-wait case: all enables 0 and all flushes 0 (no bubble without fetch progress).
REQ-021 Simultaneous control hazard and load-use: control hazard SHALL win (the LW in EX is younger than the branch and is squashed).
REQ-022 stall_count SHALL increment by 1 on each rising CLK where REQ-018 applies with ihit = 1; it wraps from 0xFFFFFFFF to 0.
REQ-023 No other internal state; no X propagation from unused instruction fields into outputs.

Reset
REQ-024 When nRST = 0 at a rising CLK edge, stall_count SHALL become 0, with reset taking precedence over increment.
REQ-025 Combinational outputs SHALL be unaffected by nRST and follow REQ-016..REQ-021 at all times.
REQ-026 Reset asserted mid-stall clears only the counter; stall decoding resumes on the next cycle.

Configuration
REQ-027 Macro HAZARD_PRECISE_LOAD_USE_EN: when defined, load_use additionally requires ex_instr[20:16] != 0 and ex_instr[20:16] equal to id_instr[25:21] or id_instr[20:16]; when undefined (default build), any LW in EX causes load_use regardless of registers.

Verification
REQ-028 ihit=1, ex_instr=0, no branch/mem request -> pcEN=1, fdEN=1, dx_flush=0, all flushes 0.
REQ-029 ihit=1, ex_instr[31:26]=6'b100011 (default build) -> pcEN=0, fdEN=0, dx_flush=1, dxEN=1; stall_count +1 per clock.
REQ-030 ihit=1, LW in EX, mem_branch_taken=1 -> all enables 1, fd/dx/xm_flush=1, stall_count unchanged.
REQ-031 dmem_req=1, dhit=0, LW in EX -> all enables 0, all flushes 0; then dhit=1 -> load-use response of REQ-029.
REQ-032 Counter at 5 with nRST=0 for one edge -> 0; with macro defined, LW rt=5 vs ID rs=6, rt=7 -> no stall; ID rs=5 -> stall.

Source files
------------

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: signal bundle between the hazard unit and the pipeline
//   hu modport: fetch/memory handshakes and EX/ID instructions in,
//   PC/latch enables, latch flushes and the load-use stall counter out.
interface hazard_unit_if;
  logic        ihit;
  logic        dhit;
  logic        dmem_req;
  logic [31:0] ex_instr;
  logic [31:0] id_instr;
  logic        mem_branch_taken;
  logic        mem_jump;
  logic        pcEN;
  logic        fdEN;
  logic        dxEN;
  logic        xmEN;
  logic        mwEN;
  logic        fd_flush;
  logic        dx_flush;
  logic        xm_flush;
  logic [31:0] stall_count;
  modport hu (
    input  ihit, dhit, dmem_req, ex_instr, id_instr, mem_branch_taken, mem_jump,
    output pcEN, fdEN, dxEN, xmEN, mwEN, fd_flush, dx_flush, xm_flush, stall_count
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control with a load-use stall counter
//   CLK   rising-edge clock
//   nRST  synchronous active-low reset (clears stall_count only)
//   huif  hazard_unit_if.hu: enables/flushes are combinational, stall_count registered
//   HAZARD_PRECISE_LOAD_USE_EN: when defined, load-use requires a real register
//   dependence between the LW destination and the ID source registers.
module hazard_unit (
  input logic       CLK,
  input logic       nRST,
  hazard_unit_if.hu huif
);
  localparam logic [5:0] LW = 6'b100011;
  logic load_use, mem_wait, ctrl, go, lu;
`ifdef HAZARD_PRECISE_LOAD_USE_EN
  logic [4:0] ex_rt;
  assign ex_rt    = huif.ex_instr[20:16];
  assign load_use = huif.ex_instr[31:26] == LW && ex_rt != 5'd0 &&
                    (ex_rt == huif.id_instr[25:21] || ex_rt == huif.id_instr[20:16]);
`else
  assign load_use = huif.ex_instr[31:26] == LW;
`endif
  assign mem_wait = huif.dmem_req & ~huif.dhit;
  assign ctrl     = huif.mem_branch_taken | huif.mem_jump;
  // Nothing moves or bubbles without fetch progress, and nothing during a memory wait.
  assign go       = ~mem_wait & huif.ihit;
  // A control hazard squashes the younger LW, so it overrides load-use.
  assign lu       = load_use & ~ctrl;
  assign huif.pcEN     = go & ~lu;
  assign huif.fdEN     = go & ~lu;
  assign huif.dxEN     = go;
  assign huif.xmEN     = go;
  assign huif.mwEN     = go;
  assign huif.fd_flush = go & ctrl;
  assign huif.dx_flush = go & (ctrl | lu);
  assign huif.xm_flush = go & ctrl;
  logic [31:0] cnt;
  always_ff @(posedge CLK)
    if (!nRST) cnt <= '0;
    else if (go & lu) cnt <= cnt + 32'd1;
  assign huif.stall_count = cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit
module tb_hazard_unit;
  logic CLK = 1'b0;
  logic nRST;
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_cnt;
  hazard_unit_if huif ();
  hazard_unit dut (.CLK(CLK), .nRST(nRST), .huif(huif));
  always #5 CLK = ~CLK;
  localparam logic [7:0] NORMAL = 8'b11111_000;
  localparam logic [7:0] IDLE   = 8'b00000_000;
  localparam logic [7:0] LUSE   = 8'b00111_010;
  localparam logic [7:0] CTRL   = 8'b11111_111;
  localparam logic [31:0] LW5   = {6'b100011, 5'd0, 5'd5, 16'h1234};
  localparam logic [31:0] ID_RS5 = {6'd0, 5'd5, 5'd9, 16'h0020};
  localparam logic [31:0] ID_67  = {6'd0, 5'd6, 5'd7, 16'h0020};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return {24'd0, huif.pcEN, huif.fdEN, huif.dxEN, huif.xmEN, huif.mwEN,
            huif.fd_flush, huif.dx_flush, huif.xm_flush};
  endfunction
  task automatic set(input logic ih, input logic dh, input logic dr, input logic br,
                     input logic jp, input logic [31:0] ex, input logic [31:0] id);
    huif.ihit = ih; huif.dhit = dh; huif.dmem_req = dr;
    huif.mem_branch_taken = br; huif.mem_jump = jp;
    huif.ex_instr = ex; huif.id_instr = id;
    #1;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  initial begin
    nRST = 1'b0;
    set(1, 0, 0, 0, 0, 32'd0, 32'd0);
    tick(); tick();
    check("reset_count", huif.stall_count, 32'd0);
    exp_cnt = 0;
    nRST = 1'b1;
    set(1, 0, 0, 0, 0, 32'd0, 32'd0);
    check("normal", outs(), {24'd0, NORMAL});
    set(0, 0, 0, 0, 0, 32'd0, 32'd0);
    check("normal_noihit", outs(), {24'd0, IDLE});
    set(1, 0, 0, 0, 0, LW5, ID_RS5);
    check("load_use", outs(), {24'd0, LUSE});
    tick(); exp_cnt++;
    check("cnt_1", huif.stall_count, exp_cnt);
    tick(); exp_cnt++;
    check("cnt_2", huif.stall_count, exp_cnt);
    set(0, 0, 0, 0, 0, LW5, ID_RS5);
    check("lu_noihit", outs(), {24'd0, IDLE});
    tick();
    check("cnt_lu_noihit", huif.stall_count, exp_cnt);
    set(1, 0, 0, 1, 0, LW5, ID_RS5);
    check("branch_over_lu", outs(), {24'd0, CTRL});
    tick();
    check("cnt_branch", huif.stall_count, exp_cnt);
    set(1, 0, 0, 0, 1, LW5, ID_RS5);
    check("jump_over_lu", outs(), {24'd0, CTRL});
    set(0, 0, 0, 1, 0, 32'd0, 32'd0);
    check("branch_noihit", outs(), {24'd0, IDLE});
    set(1, 0, 1, 1, 0, LW5, ID_RS5);
    check("mem_wait", outs(), {24'd0, IDLE});
    tick();
    check("cnt_mem_wait", huif.stall_count, exp_cnt);
    set(1, 1, 1, 0, 0, LW5, ID_RS5);
    check("mem_done_lu", outs(), {24'd0, LUSE});
    tick(); exp_cnt++;
    check("cnt_3", huif.stall_count, exp_cnt);
    tick(); tick(); exp_cnt += 2;
    check("cnt_5", huif.stall_count, exp_cnt);
    nRST = 1'b0;
    #1;
    check("lu_during_reset", outs(), {24'd0, LUSE});
    tick(); exp_cnt = 0;
    check("cnt_reset", huif.stall_count, exp_cnt);
    nRST = 1'b1;
    tick(); exp_cnt++;
    check("cnt_after_reset", huif.stall_count, exp_cnt);
`ifdef HAZARD_PRECISE_LOAD_USE_EN
    set(1, 0, 0, 0, 0, LW5, ID_67);
    check("precise_no_dep", outs(), {24'd0, NORMAL});
    tick();
    check("cnt_no_dep", huif.stall_count, exp_cnt);
    set(1, 0, 0, 0, 0, {6'b100011, 5'd0, 5'd0, 16'd0}, 32'd0);
    check("precise_rt0", outs(), {24'd0, NORMAL});
`else
    set(1, 0, 0, 0, 0, LW5, ID_67);
    check("coarse_no_dep", outs(), {24'd0, LUSE});
    tick(); exp_cnt++;
    check("cnt_no_dep", huif.stall_count, exp_cnt);
`endif
    set(1, 0, 0, 0, 0, {6'b100011, 26'h3ffffff}, ID_RS5);
`ifdef HAZARD_PRECISE_LOAD_USE_EN
    check("lw_rt31_nodep", outs(), {24'd0, NORMAL});
`else
    check("lw_any_fields", outs(), {24'd0, LUSE});
`endif
    set(1, 0, 0, 0, 0, {6'b100010, 5'd0, 5'd5, 16'd0}, ID_RS5);
    check("non_lw_op", outs(), {24'd0, NORMAL});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
